mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the data-memory side of the pipelined core.
- Consumes the core's M-stage store bus (MemWriteM / DataAdrM / WriteDataM) as the responder for stores to its address window.
- Buffers store bytes in a FIFO and serializes them 8N1 on `tx`.
- Returns a combinational status word for loads from its status address.

Parameters:
- TX_ADDR, 32'hFFFF_0000, store address whose low byte is enqueued for transmit
- STAT_ADDR, 32'hFFFF_0004, status/control register address
- CLKS_PER_BIT, 16, clk cycles per serial bit (>= 2)
- FIFO_DEPTH, 8, transmit FIFO entries (power of two, >= 2)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- MemWriteM  in  1  store strobe from M stage
- DataAdrM  in  32  store/load address
- WriteDataM  in  32  store data
- ReadDataM  out  32  status word when DataAdrM==STAT_ADDR, else 0
- HitM  out  1  DataAdrM equals TX_ADDR or STAT_ADDR (core read-mux select)
- tx  out  1  serial line, idle high
- busy  out  1  FIFO non-empty or frame in progress

Behaviour:
- Reset (async, immediate) values:
  - tx=1, busy=0, FIFO empty, overflow=0, FSM IDLE, counters 0.
  - Reset mid-frame aborts the frame; tx returns high without waiting for a clock edge.
- Push:
  - A clk edge with MemWriteM=1 and DataAdrM==TX_ADDR enqueues WriteDataM[7:0]; upper bits are ignored.
  - The push is accepted if the FIFO is not full, or if a pop occurs on the same edge.
  - Otherwise the byte is dropped and sticky `overflow` is set.
- Control:
  - A store to STAT_ADDR with WriteDataM[2]=1 clears `overflow`.
  - If the same edge also has an overflowing push, set wins.
  - Other bits written to STAT_ADDR are ignored.
- Status (combinational): ReadDataM = {29'b0, overflow, full, busy} when DataAdrM==STAT_ADDR, else 32'b0.
- Stores to any other address have no effect.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register, clear the bit counter, go to START.
  - No bypass: a byte pushed at edge N is popped at edge N+1, and tx falls after edge N+1.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, CLKS_PER_BIT cycles each; the bit index wraps 7 to exit.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
  - On STOP's last cycle: if the FIFO is non-empty, pop and go to START (back-to-back frames, no idle gap); else go to IDLE.
- Frame timing: exactly 10*CLKS_PER_BIT cycles.
  - The baud counter counts 0..CLKS_PER_BIT-1 and wraps; the state advances on wrap.
- tx is registered (no glitches).
- busy = (state!=IDLE) || !empty.
- FIFO: read/write pointers with an extra wrap bit.
  - full = same index, differing wrap bit; empty = pointers equal.
  - Simultaneous push and pop on a full FIFO leaves the count unchanged.
  - Simultaneous push and pop on an empty FIFO cannot occur (no bypass).

Decomposition:
- Shared header `uart_defs.vh`:
  - FSM state encodings (IDLE=0, START=1, DATA=2, STOP=3)
  - status bit positions (BUSY=0, FULL=1, OVF=2)
  - default addresses
- One natural sub-module, `sync_fifo`:
  - parameters WIDTH, DEPTH
  - ports clk, reset, push, pop, din, dout, full, empty
  - first-word-fall-through

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=8):
- Single byte: store 0x55 to TX_ADDR at edge N.
  - Expect tx low for the 4 cycles after edge N+1, then 1,0,1,0,1,0,1,0 at 4 cycles each, then stop high 4 cycles.
  - Expect busy to fall 40 cycles after N+1.
- Back-to-back: stores 0x41 then 0x42 on consecutive cycles.
  - Expect two frames with no idle gap: frame 2 start bit begins exactly 40 cycles after frame 1 start.
- Overflow: 10 consecutive stores 0x00..0x09 while idle.
  - 0x00 is popped and 0x01..0x08 fill the FIFO; 0x09 is dropped.
  - Status read returns 32'h7 (overflow, full, busy).
  - Store 32'h4 to STAT_ADDR; status read returns 32'h3.
  - 9 frames are transmitted, values 0x00..0x08.
- Decode: store 0xAA to 32'h0000_0064 and to TX_ADDR+8.
  - Expect tx=1 throughout, busy=0, HitM=0, ReadDataM=0.
- Reset mid-frame: assert reset during DATA bit 3 of 0x0F with 2 bytes queued.
  - Expect tx=1 and busy=0 immediately.
  - After release, no frame is sent; status reads 0.
- Data masking: store 32'hDEAD_BE5A to TX_ADDR.
  - Expect data bits 0,1,0,1,1,0,1,0 (0x5A LSB first).

Source files
------------

// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Holds the transmit FSM state encoding, the bit positions of the status
// word returned to the core, and the default MMIO addresses.
package mmio_uart_tx_pkg;

  // Transmit FSM states; encodings are fixed so firmware/debug views agree.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Status word bit positions.
  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_FULL_BIT = 1;
  localparam int STAT_OVF_BIT  = 2;

  // Default address window.
  localparam logic [31:0] DEFAULT_TX_ADDR   = 32'hFFFF_0000;
  localparam logic [31:0] DEFAULT_STAT_ADDR = 32'hFFFF_0004;

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous first-word-fall-through FIFO used as the UART transmit buffer.
// Ports:
//   clk, reset   - clock (rising edge) and asynchronous active-high reset
//   push, din    - write request and data; accepted when not full or when a
//                  pop happens on the same edge
//   pop          - read request; ignored while empty
//   dout         - current head entry (valid whenever empty is low)
//   full, empty  - occupancy flags derived from wrap-bit pointers
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             wr_en;
  logic             rd_en;

  // The extra MSB on each pointer distinguishes full from empty when the
  // index bits coincide.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop on the same edge frees the slot, so a push into a full FIFO is
  // still accepted in that case.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  assign dout = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only observed once written.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core's M-stage data bus.
// Ports:
//   clk, reset  - system clock and asynchronous active-high reset
//   MemWriteM   - store strobe
//   DataAdrM    - load/store address
//   WriteDataM  - store data; low byte is queued on a TX_ADDR store,
//                 bit 2 clears the overflow flag on a STAT_ADDR store
//   ReadDataM   - {29'b0, overflow, full, busy} when addressing STAT_ADDR
//   HitM        - address falls in this block's window (read-mux select)
//   tx          - registered serial output, idle high
//   busy        - a frame is in progress or bytes are waiting
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] TX_ADDR      = DEFAULT_TX_ADDR,
  parameter logic [31:0] STAT_ADDR    = DEFAULT_STAT_ADDR,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [31:0] DataAdrM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        HitM,
  output logic        tx,
  output logic        busy
);

  localparam int               BW       = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]    BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  uart_state_e   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          overflow_q, overflow_d;

  logic          hit_tx;
  logic          hit_stat;
  logic          push;
  logic          pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic          baud_wrap;
  logic          unused_wdata;

  assign hit_tx   = (DataAdrM == TX_ADDR);
  assign hit_stat = (DataAdrM == STAT_ADDR);
  assign push     = MemWriteM && hit_tx;
  assign HitM     = hit_tx || hit_stat;

  assign unused_wdata = ^WriteDataM[31:8];

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .din  (WriteDataM[7:0]),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Sticky overflow: a dropped push sets it, a STAT store with bit 2 clears
  // it. Set is evaluated last so it wins when both occur on one edge.
  always_comb begin
    overflow_d = overflow_q;
    if (MemWriteM && hit_stat && WriteDataM[STAT_OVF_BIT]) overflow_d = 1'b0;
    if (push && fifo_full && !pop) overflow_d = 1'b1;
  end

  assign baud_wrap = (baud_q == BAUD_MAX);

  // Frame sequencer. tx_d is the value the line takes after this edge, so
  // each state transition also loads the first level of the next state.
  // The baud counter only runs outside IDLE; the state advances on its wrap.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_d   = fifo_dout;
          bit_idx_d = 3'd0;
          tx_d      = 1'b0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        baud_d = baud_wrap ? '0 : baud_q + 1'b1;
        if (baud_wrap) begin
          tx_d    = shift_q[0];
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        baud_d = baud_wrap ? '0 : baud_q + 1'b1;
        if (baud_wrap) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      ST_STOP: begin
        baud_d = baud_wrap ? '0 : baud_q + 1'b1;
        if (baud_wrap) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_d   = fifo_dout;
            bit_idx_d = 3'd0;
            tx_d      = 1'b0;
            state_d   = ST_START;
          end else begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != ST_IDLE) || !fifo_empty;

  always_comb begin
    ReadDataM = 32'b0;
    if (hit_stat) begin
      ReadDataM[STAT_BUSY_BIT] = busy;
      ReadDataM[STAT_FULL_BIT] = fifo_full;
      ReadDataM[STAT_OVF_BIT]  = overflow_q;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx with CLKS_PER_BIT=4 and
// FIFO_DEPTH=8. All timing is tracked in whole clock cycles from the edge
// that pops a byte; outputs are sampled 1ns after each rising edge.
module tb_mmio_uart_tx;

  localparam logic [31:0] TX_ADDR   = 32'hFFFF_0000;
  localparam logic [31:0] STAT_ADDR = 32'hFFFF_0004;
  localparam int          CPB       = 4;

  logic        clk;
  logic        reset;
  logic        MemWriteM;
  logic [31:0] DataAdrM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        HitM;
  logic        tx;
  logic        busy;

  int testCount = 0;
  int failCount = 0;

  mmio_uart_tx #(
    .TX_ADDR     (TX_ADDR),
    .STAT_ADDR   (STAT_ADDR),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWriteM (MemWriteM),
    .DataAdrM  (DataAdrM),
    .WriteDataM(WriteDataM),
    .ReadDataM (ReadDataM),
    .HitM      (HitM),
    .tx        (tx),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1ns past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the bus inputs.
  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] data);
    MemWriteM  = we;
    DataAdrM   = addr;
    WriteDataM = data;
  endtask

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h, required %h", tag, observed, expected);
    end
  endtask

  // One store cycle; the write lands on the next rising edge.
  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, addr, data);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0);
  endtask

  // Check tx and busy for frame cycles firstCycle..39, where cycle 0 is the
  // first cycle after the popping edge. Leaves time at cycle 0 of whatever
  // follows the frame.
  task automatic checkFrame(input string tag, input logic [7:0] data,
                            input int firstCycle);
    logic [9:0] frame;
    frame = {1'b1, data, 1'b0};
    for (int c = firstCycle; c < 10 * CPB; c++) begin
      checkOutput({tag, " tx"}, {31'b0, tx}, {31'b0, frame[c / CPB]});
      checkOutput({tag, " busy"}, {31'b0, busy}, 32'd1);
      tick();
    end
  endtask

  initial begin
    logic [9:0] rframe;

    applyStimulus(1'b0, STAT_ADDR, 32'h0);
    reset = 1'b1;
    #2;
    checkOutput("reset tx", {31'b0, tx}, 32'd1);
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    checkOutput("reset status", ReadDataM, 32'h0);
    checkOutput("reset hit stat", {31'b0, HitM}, 32'd1);
    applyStimulus(1'b0, TX_ADDR, 32'h0);
    #1;
    checkOutput("hit tx", {31'b0, HitM}, 32'd1);
    checkOutput("tx addr read", ReadDataM, 32'h0);
    applyStimulus(1'b0, 32'h0, 32'h0);
    tick();
    reset = 1'b0;
    tick();

    // Single byte: no bypass, so tx is still high right after the push.
    store(TX_ADDR, 32'h55);
    checkOutput("single busy after push", {31'b0, busy}, 32'd1);
    checkOutput("single tx after push", {31'b0, tx}, 32'd1);
    tick();
    checkFrame("single", 8'h55, 0);
    checkOutput("single busy end", {31'b0, busy}, 32'd0);
    checkOutput("single tx end", {31'b0, tx}, 32'd1);
    tick();

    // Back-to-back frames with no idle gap.
    store(TX_ADDR, 32'h41);
    checkOutput("b2b tx after push", {31'b0, tx}, 32'd1);
    store(TX_ADDR, 32'h42);
    checkFrame("b2b first", 8'h41, 0);
    checkFrame("b2b second", 8'h42, 0);
    checkOutput("b2b busy end", {31'b0, busy}, 32'd0);
    tick();

    // Overflow: ten pushes while idle; byte 0x09 is dropped.
    for (int i = 0; i < 10; i++) store(TX_ADDR, i);
    applyStimulus(1'b0, STAT_ADDR, 32'h0);
    #1;
    checkOutput("ovf status", ReadDataM, 32'h7);
    checkOutput("ovf hit", {31'b0, HitM}, 32'd1);
    #1;
    store(STAT_ADDR, 32'h4);
    applyStimulus(1'b0, STAT_ADDR, 32'h0);
    #1;
    checkOutput("ovf cleared status", ReadDataM, 32'h3);
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkFrame("ovf frame 0", 8'h00, 9);
    for (int i = 1; i < 9; i++) checkFrame($sformatf("ovf frame %0d", i), 8'(i), 0);
    checkOutput("ovf busy end", {31'b0, busy}, 32'd0);
    applyStimulus(1'b0, STAT_ADDR, 32'h0);
    #1;
    checkOutput("ovf final status", ReadDataM, 32'h0);
    applyStimulus(1'b0, 32'h0, 32'h0);
    tick();

    // Decode: stores outside the window do nothing.
    applyStimulus(1'b1, 32'h0000_0064, 32'hAA);
    #1;
    checkOutput("decode low hit", {31'b0, HitM}, 32'd0);
    checkOutput("decode low read", ReadDataM, 32'h0);
    tick();
    applyStimulus(1'b1, TX_ADDR + 32'd8, 32'hAA);
    #1;
    checkOutput("decode high hit", {31'b0, HitM}, 32'd0);
    checkOutput("decode high read", ReadDataM, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0);
    for (int c = 0; c < 12; c++) begin
      checkOutput("decode tx", {31'b0, tx}, 32'd1);
      checkOutput("decode busy", {31'b0, busy}, 32'd0);
      tick();
    end

    // Reset mid-frame during data bit 3 of 0x0F, two bytes still queued.
    store(TX_ADDR, 32'h0F);
    store(TX_ADDR, 32'h11);
    store(TX_ADDR, 32'h22);
    applyStimulus(1'b0, STAT_ADDR, 32'h0);
    #1;
    checkOutput("rst status before", ReadDataM, 32'h1);
    rframe = {1'b1, 8'h0F, 1'b0};
    for (int c = 1; c < 4 * CPB + 1; c++) begin
      checkOutput("rst frame tx", {31'b0, tx}, {31'b0, rframe[c / CPB]});
      tick();
    end
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst async tx", {31'b0, tx}, 32'd1);
    checkOutput("rst async busy", {31'b0, busy}, 32'd0);
    checkOutput("rst async status", ReadDataM, 32'h0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 50; c++) begin
      checkOutput("rst after tx", {31'b0, tx}, 32'd1);
      checkOutput("rst after busy", {31'b0, busy}, 32'd0);
      tick();
    end
    checkOutput("rst after status", ReadDataM, 32'h0);
    applyStimulus(1'b0, 32'h0, 32'h0);
    tick();

    // Data masking: only the low byte is transmitted.
    store(TX_ADDR, 32'hDEAD_BE5A);
    checkOutput("mask tx after push", {31'b0, tx}, 32'd1);
    tick();
    checkFrame("mask", 8'h5A, 0);
    checkOutput("mask busy end", {31'b0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
